// File: rtl/kf6845_init_sequencer.sv
// ============================================================================
// Module   : kf6845_init_sequencer
// Brief    : Programs CRTC R0..R(REG_COUNT-1) from a CGA mode table and
//            arbitrates the CRTC bus with a registered host pass-through.
//            Optional macro KF6845_INIT_RESTORE_ADDR_EN restores the host's
//            last CRTC address register selection after the sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kf6845_init_sequencer #(
    parameter int REG_COUNT  = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode_select,
    input  logic       host_cs_n,
    input  logic       host_rs,
    input  logic       host_enable,
    input  logic       host_r_or_w,
    input  logic [7:0] host_data,
    output logic       crtc_cs_n,
    output logic       crtc_rs,
    output logic       crtc_enable,
    output logic       crtc_r_or_w,
    output logic [7:0] crtc_data,
    output logic       busy,
    output logic       done,
    output logic       host_wait
);

    localparam logic [3:0] c_LAST_INDEX = 4'(REG_COUNT - 1);
    localparam logic [2:0] c_GAP_LAST   = 3'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_WAIT_HOST   = 4'd1,
        ST_ADDR_STROBE = 4'd2,
        ST_ADDR_GAP    = 4'd3,
        ST_DATA_STROBE = 4'd4,
        ST_DATA_GAP    = 4'd5,
`ifdef KF6845_INIT_RESTORE_ADDR_EN
        ST_RESTORE_STROBE = 4'd7,
        ST_RESTORE_GAP    = 4'd8,
`endif
        ST_DONE        = 4'd6
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_index;
    logic [1:0] r_mode;
    logic [2:0] r_gap_cnt;
    logic       w_in_gap;
    logic       w_gap_last;
    logic       w_host_active;

    logic       r_cs_n, r_rs, r_en, r_rw, r_busy, r_done, r_host_wait;
    logic [7:0] r_data;
    logic       w_cs_n, w_rs, w_en, w_rw, w_busy, w_done, w_host_wait;
    logic [7:0] w_data;

    // CGA register values; 0/3 use 80-column horizontal timing, 2/3 graphics vertical timing.
    function automatic logic [7:0] f_table(input logic [1:0] mode, input logic [3:0] idx);
        logic wide;
        logic gfx;
        wide = (mode == 2'd0) || (mode == 2'd3);
        gfx  = mode[1];
        case (idx)
            4'd0:    f_table = wide ? 8'h71 : 8'h38;
            4'd1:    f_table = wide ? 8'h50 : 8'h28;
            4'd2:    f_table = wide ? 8'h5A : 8'h2D;
            4'd3:    f_table = 8'h0A;
            4'd4:    f_table = gfx ? 8'h7F : 8'h1F;
            4'd5:    f_table = 8'h06;
            4'd6:    f_table = gfx ? 8'h64 : 8'h19;
            4'd7:    f_table = gfx ? 8'h70 : 8'h1C;
            4'd8:    f_table = 8'h02;
            4'd9:    f_table = gfx ? 8'h01 : 8'h07;
            4'd10:   f_table = 8'h06;
            4'd11:   f_table = 8'h07;
            default: f_table = 8'h00;
        endcase
    endfunction

    assign w_host_active = !host_cs_n && host_enable;
    assign w_gap_last    = (r_gap_cnt == c_GAP_LAST);

`ifdef KF6845_INIT_RESTORE_ADDR_EN
    logic [4:0] r_shadow;

    assign w_in_gap = (r_state == ST_ADDR_GAP) || (r_state == ST_DATA_GAP)
                   || (r_state == ST_RESTORE_GAP);

    // Only address writes that actually reach the CRTC are worth restoring.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow <= 5'd0;
        end else if (((r_state == ST_IDLE) || (r_state == ST_WAIT_HOST))
                     && w_host_active && !host_rs && !host_r_or_w) begin
            r_shadow <= host_data[4:0];
        end
    end
`else
    assign w_in_gap = (r_state == ST_ADDR_GAP) || (r_state == ST_DATA_GAP);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_index   <= 4'd0;
            r_mode    <= 2'd0;
            r_gap_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= (w_in_gap && !w_gap_last) ? r_gap_cnt + 3'd1 : 3'd0;
            if (r_state == ST_IDLE && start) begin
                r_mode  <= mode_select;
                r_index <= 4'd0;
            end else if (r_state == ST_DATA_GAP && w_gap_last && r_index != c_LAST_INDEX) begin
                r_index <= r_index + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_host_active ? ST_WAIT_HOST : ST_ADDR_STROBE;
                end
            end
            ST_WAIT_HOST: begin
                if (!w_host_active) begin
                    w_state_nxt = ST_ADDR_STROBE;
                end
            end
            ST_ADDR_STROBE: w_state_nxt = ST_ADDR_GAP;
            ST_ADDR_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = ST_DATA_STROBE;
                end
            end
            ST_DATA_STROBE: w_state_nxt = ST_DATA_GAP;
            ST_DATA_GAP: begin
                if (w_gap_last) begin
`ifdef KF6845_INIT_RESTORE_ADDR_EN
                    w_state_nxt = (r_index == c_LAST_INDEX) ? ST_RESTORE_STROBE : ST_ADDR_STROBE;
`else
                    w_state_nxt = (r_index == c_LAST_INDEX) ? ST_DONE : ST_ADDR_STROBE;
`endif
                end
            end
`ifdef KF6845_INIT_RESTORE_ADDR_EN
            ST_RESTORE_STROBE: w_state_nxt = ST_RESTORE_GAP;
            ST_RESTORE_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus values are decoded from the current state and registered, so every
    // bus phase appears one clock after the state that produces it is entered.
    always_comb begin
        w_cs_n      = 1'b1;
        w_rs        = 1'b1;
        w_en        = 1'b0;
        w_rw        = 1'b1;
        w_data      = 8'hFF;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_host_wait = !host_cs_n;
        case (r_state)
            ST_IDLE, ST_WAIT_HOST: begin
                w_cs_n      = host_cs_n;
                w_rs        = host_rs;
                w_en        = host_enable;
                w_rw        = host_r_or_w;
                w_data      = host_data;
                w_host_wait = 1'b0;
                w_busy      = (r_state == ST_WAIT_HOST);
            end
            ST_ADDR_STROBE: begin
                w_cs_n = 1'b0;
                w_rs   = 1'b0;
                w_en   = 1'b1;
                w_rw   = 1'b0;
                w_data = {4'b0000, r_index};
            end
            ST_DATA_STROBE: begin
                w_cs_n = 1'b0;
                w_en   = 1'b1;
                w_rw   = 1'b0;
                w_data = f_table(r_mode, r_index);
            end
`ifdef KF6845_INIT_RESTORE_ADDR_EN
            ST_RESTORE_STROBE: begin
                w_cs_n = 1'b0;
                w_rs   = 1'b0;
                w_en   = 1'b1;
                w_rw   = 1'b0;
                w_data = {3'b000, r_shadow};
            end
`endif
            ST_DONE: begin
                w_busy      = 1'b0;
                w_done      = 1'b1;
                w_host_wait = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cs_n      <= 1'b1;
            r_rs        <= 1'b1;
            r_en        <= 1'b0;
            r_rw        <= 1'b1;
            r_data      <= 8'hFF;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_host_wait <= 1'b0;
        end else begin
            r_cs_n      <= w_cs_n;
            r_rs        <= w_rs;
            r_en        <= w_en;
            r_rw        <= w_rw;
            r_data      <= w_data;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_host_wait <= w_host_wait;
        end
    end

    assign crtc_cs_n   = r_cs_n;
    assign crtc_rs     = r_rs;
    assign crtc_enable = r_en;
    assign crtc_r_or_w = r_rw;
    assign crtc_data   = r_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign host_wait   = r_host_wait;

endmodule

`default_nettype wire

// File: tb/tb_kf6845_init_sequencer.sv
// ============================================================================
// Module   : tb_kf6845_init_sequencer
// Brief    : Scoreboard bench for kf6845_init_sequencer (write strobes + done).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kf6845_init_sequencer;

    localparam int REG  = 16;
    localparam int GAP  = 1;
    localparam int PER  = 2 * (1 + GAP);

    logic       clock, reset, start;
    logic [1:0] mode_select;
    logic       host_cs_n, host_rs, host_enable, host_r_or_w;
    logic [7:0] host_data;
    logic       crtc_cs_n, crtc_rs, crtc_enable, crtc_r_or_w;
    logic [7:0] crtc_data;
    logic       busy, done, host_wait;

    kf6845_init_sequencer #(.REG_COUNT(REG), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset(reset), .start(start), .mode_select(mode_select),
        .host_cs_n(host_cs_n), .host_rs(host_rs), .host_enable(host_enable),
        .host_r_or_w(host_r_or_w), .host_data(host_data),
        .crtc_cs_n(crtc_cs_n), .crtc_rs(crtc_rs), .crtc_enable(crtc_enable),
        .crtc_r_or_w(crtc_r_or_w), .crtc_data(crtc_data),
        .busy(busy), .done(done), .host_wait(host_wait)
    );

    typedef struct packed {
        logic       is_done;
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic [7:0] c_tbl [0:3][0:15] = '{
        '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    ev_t        exp_q[$];
    ev_t        mon_obs, mon_exp;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_reads = 0;
    int         exp_reads = 0;
    logic [4:0] exp_shadow = 5'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic ev_t mk(input logic d, input logic rs, input logic [7:0] data, input int c);
        ev_t e;
        e.is_done = d;
        e.rs      = rs;
        e.data    = data;
        e.cyc     = c;
        return e;
    endfunction

    // s is the cycle number of the edge that accepts the start (or host release).
    task automatic push_run(input logic [1:0] m, input int s, input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 8'(i), s + 1 + i * PER));
            exp_q.push_back(mk(1'b0, 1'b1, c_tbl[m][i], s + 1 + i * PER + 1 + GAP));
        end
        if (full) begin
`ifdef KF6845_INIT_RESTORE_ADDR_EN
            exp_q.push_back(mk(1'b0, 1'b0, {3'b000, exp_shadow}, s + 1 + n * PER));
            exp_q.push_back(mk(1'b1, 1'b0, 8'h00, s + 1 + n * PER + 1 + GAP));
`else
            exp_q.push_back(mk(1'b1, 1'b0, 8'h00, s + 1 + n * PER));
`endif
        end
    endtask

    task automatic start_seq(input logic [1:0] m);
        int s;
        @(negedge clock);
        start = 1'b1;
        mode_select = m;
        s = cyc + 1;
        push_run(m, s, REG, 1'b1);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("busy_falls_with_done", {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic host_idle();
        host_cs_n = 1'b1; host_enable = 1'b0; host_rs = 1'b1;
        host_r_or_w = 1'b1; host_data = 8'hFF;
    endtask

    task automatic host_addr_write(input logic [7:0] d);
        host_cs_n = 1'b0; host_enable = 1'b1; host_rs = 1'b0;
        host_r_or_w = 1'b0; host_data = d;
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_cs_n"}, {31'd0, crtc_cs_n}, 32'd1);
        chk({tag, "_rs"}, {31'd0, crtc_rs}, 32'd1);
        chk({tag, "_enable"}, {31'd0, crtc_enable}, 32'd0);
        chk({tag, "_r_or_w"}, {31'd0, crtc_r_or_w}, 32'd1);
        chk({tag, "_data"}, {24'd0, crtc_data}, 32'hFF);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_host_wait"}, {31'd0, host_wait}, 32'd0);
    endtask

    // Monitor: every write strobe and every done pulse consumes one expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (!crtc_cs_n && crtc_enable && crtc_r_or_w) n_reads++;
            if ((!crtc_cs_n && crtc_enable && !crtc_r_or_w) || done) begin
                mon_obs = mk(done, done ? 1'b0 : crtc_rs, done ? 8'h00 : crtc_data, cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: got done=%0b rs=%0b data=%02h cyc=%0d, none expected",
                             mon_obs.is_done, mon_obs.rs, mon_obs.data, mon_obs.cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_obs == mon_exp) n_pass++;
                    else $display("FAIL bus_event: got done=%0b rs=%0b data=%02h cyc=%0d expected done=%0b rs=%0b data=%02h cyc=%0d",
                                  mon_obs.is_done, mon_obs.rs, mon_obs.data, mon_obs.cyc,
                                  mon_exp.is_done, mon_exp.rs, mon_exp.data, mon_exp.cyc);
                end
            end
        end
    end

    initial begin
        int s, h, r;
        reset = 1'b1;
        start = 1'b0;
        mode_select = 2'd0;
        host_idle();
        repeat (10) @(negedge clock);
        chk_idle_bus("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Mode 0 full sequence.
        start_seq(2'd0);
        wait_done();

        // Mode 3 with a host address write blocked while busy.
        start_seq(2'd3);
        repeat (5) @(negedge clock);
        host_addr_write(8'h0E);
        @(negedge clock);
        chk("host_wait_busy", {31'd0, host_wait}, 32'd1);
        host_idle();
        @(negedge clock);
        chk("host_wait_released", {31'd0, host_wait}, 32'd0);
        wait_done();

        // Same host write in IDLE is forwarded one cycle later.
        @(negedge clock);
        host_addr_write(8'h0E);
        exp_q.push_back(mk(1'b0, 1'b0, 8'h0E, cyc + 1));
        exp_shadow = 5'h0E;
        @(negedge clock);
        host_idle();
        chk("host_wait_idle", {31'd0, host_wait}, 32'd0);
        repeat (2) @(negedge clock);

        // Start during an active host read: sequence waits for release.
        host_cs_n = 1'b0; host_enable = 1'b1; host_rs = 1'b1;
        host_r_or_w = 1'b1; host_data = 8'h00;
        h = cyc + 1;
        @(negedge clock);
        start = 1'b1;
        mode_select = 2'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        host_idle();
        r = cyc + 1;
        exp_reads += r - h;
        push_run(2'd1, r, REG, 1'b1);
        wait_done();
        repeat (2) @(negedge clock);

        // Restart attempt at index 5, then reset at index 8.
        @(negedge clock);
        start = 1'b1;
        mode_select = 2'd2;
        s = cyc + 1;
        push_run(2'd2, s, 8, 1'b0);
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        start = 1'b1;
        mode_select = 2'd0;
        @(negedge clock);
        start = 1'b0;
        repeat (12) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_idle_bus("abort");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("read_strobes", n_reads, exp_reads);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
